// File: rtl/serial_sub_if.sv
// serial_sub_if -- handshake and data bundle for the bit-serial subtractor.
//
// Signals:
//   start  request from the controller, only looked at while the unit is idle
//   a, b   minuend and subtrahend, W bits each
//   bin    borrow-in
//   busy   unit is working (RUN or DONE)
//   done   one-cycle result-valid pulse
//   diff   (a - b - bin) mod 2^W, held until the next completion
//   bout   final borrow-out, 1 when a < b + bin
//
// Modports:
//   master  controller side: drives the request and operands
//   slave   subtractor side: drives status and result
interface serial_sub_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_sub.sv
// serial_sub -- bit-serial full subtractor, one bit per clock, LSB first.
//
// A single full-subtractor cell is reused for every bit position.  The
// borrow between positions lives in one flop.  The operands are shifted
// right past the cell.  Difference bits enter the result register at the
// MSB, so after W shifts the result sits in its natural bit order.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   serial_sub_if.slave
//           start/a/b/bin in; busy/done/diff/bout out, all registered
//
// Timing: start accepted at edge k -> done high in the cycle after edge k+W.
// busy covers the W RUN cycles plus the DONE cycle.
module serial_sub #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_sr_q, a_sr_d;
  logic [W-1:0]   b_sr_q, b_sr_d;
  logic [W-1:0]   res_q, res_d;
  logic           bor_q, bor_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           bout_q, bout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           diff_bit_s;
  logic           bor_next_s;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  function automatic logic [1:0] fsub_cell(input logic ai, input logic bi, input logic bori);
    logic d;
    logic bo;
    d  = ai ^ bi ^ bori;
    bo = (~ai & bi) | (~(ai ^ bi) & bori);
    return {bo, d};
  endfunction

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;

    {bor_next_s, diff_bit_s} = fsub_cell(a_sr_q[0], b_sr_q[0], bor_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          bor_d   = bus.bin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_sr_d = {1'b0, a_sr_q[W-1:1]};
        b_sr_d = {1'b0, b_sr_q[W-1:1]};
        res_d  = {diff_bit_s, res_q[W-1:1]};
        bor_d  = bor_next_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the result including the bit produced now.
          diff_d  = {diff_bit_s, res_q[W-1:1]};
          bout_d  = bor_next_s;
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they are flop outputs.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub -- directed table plus multi-cycle sequences for serial_sub
// at W=8 and W=16, with a bench-side reference for the random operations.
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_sub_if #(.W(8))  bus8 ();
  serial_sub_if #(.W(16)) bus16 ();

  serial_sub #(.W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub #(.W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] exp_diff;
    logic        exp_bout;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic st, input logic [15:0] a, input logic [15:0] b,
                       input logic bin);
    if (w == 8) begin
      bus8.start = st;
      bus8.a     = a[7:0];
      bus8.b     = b[7:0];
      bus8.bin   = bin;
    end else begin
      bus16.start = st;
      bus16.a     = a;
      bus16.b     = b;
      bus16.bin   = bin;
    end
  endtask

  task automatic sample(input int w, output logic busy, output logic done,
                        output logic [15:0] diff, output logic bout);
    if (w == 8) begin
      busy = bus8.busy;
      done = bus8.done;
      diff = {8'h00, bus8.diff};
      bout = bus8.bout;
    end else begin
      busy = bus16.busy;
      done = bus16.done;
      diff = bus16.diff;
      bout = bus16.bout;
    end
  endtask

  // One complete operation: checks done count, latency, busy length and result.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] exp_diff, input logic exp_bout, input string nm);
    int          seen;
    int          lat;
    int          bc;
    logic        bs;
    logic        ds;
    logic        bo;
    logic [15:0] df;
    logic [15:0] df_done;
    seen    = 0;
    lat     = 0;
    bc      = 0;
    df_done = 16'h0000;
    @(negedge clk);
    drive(w, 1'b1, a, b, bin);
    @(negedge clk);
    // Operands scrambled right after acceptance; only captured values count.
    drive(w, 1'b0, ~a, ~b, ~bin);
    for (int i = 1; i <= w + 4; i++) begin
      sample(w, bs, ds, df, bo);
      if (bs) bc++;
      if (ds) begin
        seen++;
        if (lat == 0) lat = i;
        df_done = df;
      end
      @(negedge clk);
    end
    sample(w, bs, ds, df, bo);
    chk({nm, " done_count"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(w + 1));
    chk({nm, " busy_cycles"}, 32'(bc), 32'(w + 1));
    chk({nm, " diff_at_done"}, {16'h0000, df_done}, {16'h0000, exp_diff});
    chk({nm, " diff_held"}, {16'h0000, df}, {16'h0000, exp_diff});
    chk({nm, " bout"}, {31'd0, bo}, {31'd0, exp_bout});
  endtask

  initial begin
    logic        bs;
    logic        ds;
    logic        bo;
    logic        hb;
    logic        got;
    logic [15:0] d;
    logic [15:0] hd;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rbin;
    logic [16:0] full;
    int          dn;

    vecs[0]  = '{8,  16'd100,   16'd37,   1'b0, 16'd63,    1'b0};
    vecs[1]  = '{8,  16'd5,     16'd9,    1'b0, 16'd252,   1'b1};
    vecs[2]  = '{8,  16'd0,     16'd0,    1'b1, 16'd255,   1'b1};
    vecs[3]  = '{8,  16'd255,   16'd255,  1'b0, 16'd0,     1'b0};
    vecs[4]  = '{8,  16'd0,     16'd255,  1'b1, 16'd0,     1'b1};
    vecs[5]  = '{8,  16'd128,   16'd127,  1'b1, 16'd0,     1'b0};
    vecs[6]  = '{8,  16'd255,   16'd0,    1'b1, 16'd254,   1'b0};
    vecs[7]  = '{8,  16'd1,     16'd255,  1'b1, 16'd1,     1'b1};
    vecs[8]  = '{8,  16'd0,     16'd1,    1'b0, 16'd255,   1'b1};
    vecs[9]  = '{8,  16'd170,   16'd85,   1'b0, 16'd85,    1'b0};
    vecs[10] = '{16, 16'd0,     16'd1,    1'b0, 16'd65535, 1'b1};
    vecs[11] = '{16, 16'd40000, 16'd1234, 1'b1, 16'd38765, 1'b0};
    vecs[12] = '{16, 16'h8000,  16'h8000, 1'b1, 16'd65535, 1'b1};

    rst = 1'b1;
    drive(8, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(16, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    sample(8, bs, ds, d, bo);
    chk("reset busy", {31'd0, bs}, 32'd0);
    chk("reset done", {31'd0, ds}, 32'd0);
    chk("reset diff", {16'h0000, d}, 32'd0);
    chk("reset bout", {31'd0, bo}, 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].exp_diff, vecs[i].exp_bout,
             $sformatf("vec%0d", i));
    end

    // Asynchronous reset mid-operation, checked before the next clock edge.
    @(negedge clk);
    drive(8, 1'b1, 16'd100, 16'd37, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    sample(8, bs, ds, d, bo);
    chk("async_rst busy", {31'd0, bs}, 32'd0);
    chk("async_rst done", {31'd0, ds}, 32'd0);
    chk("async_rst diff", {16'h0000, d}, 32'd0);
    chk("async_rst bout", {31'd0, bo}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset after four bits of 50-20: no done pulse, result stays cleared.
    @(negedge clk);
    drive(8, 1'b1, 16'd50, 16'd20, 1'b0);
    @(negedge clk);
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sample(8, bs, ds, d, bo);
      if (ds) dn++;
    end
    chk("abort no_done", 32'(dn), 32'd0);
    chk("abort diff", {16'h0000, d}, 32'd0);
    chk("abort busy", {31'd0, bs}, 32'd0);
    run_op(8, 16'd50, 16'd20, 1'b0, 16'd30, 1'b0, "after_abort");

    // Start held high with operands changing while busy.
    @(negedge clk);
    drive(8, 1'b1, 16'd200, 16'd1, 1'b0);
    dn = 0;
    hd = 16'h0000;
    hb = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      sample(8, bs, ds, d, bo);
      if (ds) begin
        dn++;
        hd = d;
        hb = bo;
      end
      if (i == 9) begin
        drive(8, 1'b1, 16'd10, 16'd3, 1'b0);
      end else begin
        drive(8, 1'b1, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)));
      end
    end
    chk("held done_count", 32'(dn), 32'd1);
    chk("held diff", {16'h0000, hd}, 32'd199);
    chk("held bout", {31'd0, hb}, 32'd0);
    @(negedge clk);
    sample(8, bs, ds, d, bo);
    chk("held idle_busy", {31'd0, bs}, 32'd0);
    chk("held idle_done", {31'd0, ds}, 32'd0);
    @(negedge clk);
    sample(8, bs, ds, d, bo);
    chk("held restart_busy", {31'd0, bs}, 32'd1);
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sample(8, bs, ds, d, bo);
      if (ds) begin
        got = 1'b1;
        break;
      end
    end
    chk("held second_done", {31'd0, got}, 32'd1);
    chk("held second_diff", {16'h0000, d}, 32'd7);
    chk("held second_bout", {31'd0, bo}, 32'd0);

    // Random operations against the bench reference a - b - bin.
    for (int n = 0; n < 1000; n++) begin
      ra   = 16'($urandom_range(0, 255));
      rb   = 16'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
      run_op(8, ra, rb, rbin, {8'h00, full[7:0]}, full[8], $sformatf("rnd8_%0d", n));
    end
    for (int n = 0; n < 1000; n++) begin
      ra   = 16'($urandom_range(0, 65535));
      rb   = 16'($urandom_range(0, 65535));
      rbin = 1'($urandom_range(0, 1));
      full = {1'b0, ra} - {1'b0, rb} - {16'h0000, rbin};
      run_op(16, ra, rb, rbin, full[15:0], full[16], $sformatf("rnd16_%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
